// File: rtl/intr_cpu_ack_master.sv
// CPU-side agent for the 8-line interrupt controller bus: writes config words,
// runs the three-strobe acknowledge handshake and returns the completion word.
module intr_cpu_ack_master #(
    parameter int unsigned ACK_DELAY   = 6,
    parameter int unsigned PULSE_W     = 1,
    parameter int unsigned CFG_HOLD    = 1,
    parameter int unsigned VEC_TIMEOUT = 255
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       intr_out,
    output logic       intr_in,
    input  logic       bus_oe,
    inout  wire  [7:0] intr_bus,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [4:0] exp_prefix,
    input  logic [4:0] cmpl_prefix,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] irq_vec,
    input  logic       isr_done,
    output logic       vec_err,
    output logic       to_err,
    output logic       busy
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] DLY_END = CNT_W'(ACK_DELAY);
    localparam logic [CNT_W-1:0] PW_END  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] CFG_END = CNT_W'(CFG_HOLD);
    localparam logic [CNT_W-1:0] TO_END  = CNT_W'(VEC_TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_CFG, ST_INT_DLY, ST_ACK1, ST_VEC_WAIT, ST_VEC_DLY,
        ST_ACK2, ST_ISR, ST_CMPL_DLY, ST_ACK3, ST_ERR
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [7:0]       bus_q;
    logic             drv_en_q;
    logic             intr_in_q;
    logic             cfg_ready_q;
    logic             irq_valid_q;
    logic [2:0]       irq_id_q;
    logic [7:0]       irq_vec_q;
    logic             vec_err_q;
    logic             to_err_q;
    logic             busy_q;
    logic             drive_c;

    assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Never drive while the controller owns the bus, and always let go in ERR.
    assign drive_c  = drv_en_q & ~bus_oe & (state_q != ST_ERR);
    assign intr_bus = drive_c ? bus_q : 8'hzz;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_q       <= '0;
            drv_en_q    <= 1'b0;
            intr_in_q   <= 1'b1;
            cfg_ready_q <= 1'b0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
            irq_vec_q   <= '0;
            vec_err_q   <= 1'b0;
            to_err_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cfg_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (intr_out) begin
                        state_q <= ST_INT_DLY;
                        busy_q  <= 1'b1;
                    end else if (cfg_valid) begin
                        bus_q       <= cfg_data;
                        drv_en_q    <= 1'b1;
                        cfg_ready_q <= 1'b1;
                        state_q     <= ST_CFG;
                        busy_q      <= 1'b1;
                    end
                end
                ST_CFG: begin
                    if (cnt_q == CFG_END) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                // Shared gap before each strobe; the strobe starts on the exit edge.
                ST_INT_DLY, ST_VEC_DLY, ST_CMPL_DLY: begin
                    if (cnt_q == DLY_END) begin
                        cnt_q     <= '0;
                        intr_in_q <= 1'b0;
                        state_q   <= (state_q == ST_INT_DLY) ? ST_ACK1 :
                                     (state_q == ST_VEC_DLY) ? ST_ACK2 : ST_ACK3;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                ST_ACK1, ST_ACK2, ST_ACK3: begin
                    if (cnt_q == PW_END) begin
                        cnt_q     <= '0;
                        intr_in_q <= 1'b1;
                        if (state_q == ST_ACK1) begin
                            state_q <= ST_VEC_WAIT;
                        end else if (state_q == ST_ACK2) begin
                            irq_valid_q <= 1'b1;
                            irq_id_q    <= irq_vec_q[2:0];
                            state_q     <= ST_ISR;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                ST_VEC_WAIT: begin
                    if (bus_oe) begin
                        cnt_q     <= '0;
                        irq_vec_q <= intr_bus;
                        if (intr_bus[7:3] != exp_prefix) begin
                            vec_err_q <= 1'b1;
                            state_q   <= ST_ERR;
                        end else begin
                            state_q <= ST_VEC_DLY;
                        end
                    end else if (cnt_q == TO_END) begin
                        to_err_q <= 1'b1;
                        state_q  <= ST_ERR;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                ST_ISR: begin
                    if (isr_done) begin
                        irq_valid_q <= 1'b0;
                        bus_q       <= {cmpl_prefix, irq_id_q};
                        drv_en_q    <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_CMPL_DLY;
                    end
                end
                ST_ERR: begin
                    intr_in_q <= 1'b1;
                    busy_q    <= 1'b1;
                end
                default: begin
                    state_q <= ST_ERR;
                end
            endcase
        end
    end

    assign intr_in   = intr_in_q;
    assign cfg_ready = cfg_ready_q;
    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign irq_vec   = irq_vec_q;
    assign vec_err   = vec_err_q;
    assign to_err    = to_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_intr_cpu_ack_master.sv
// Bench for intr_cpu_ack_master: the bench plays controller and core, and predicts
// strobe timing, captured vectors and completion words from the protocol rules.
module tb_intr_cpu_ack_master;
    localparam int ACK_DELAY   = 6;
    localparam int PULSE_W     = 1;
    localparam int CFG_HOLD    = 1;
    localparam int VEC_TIMEOUT = 255;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       intr_out = 1'b0;
    logic       bus_oe = 1'b0;
    logic [7:0] cfg_data = '0;
    logic       cfg_valid = 1'b0;
    logic [4:0] exp_prefix = '0;
    logic [4:0] cmpl_prefix = '0;
    logic       isr_done = 1'b0;
    logic       intr_in, cfg_ready, irq_valid, vec_err, to_err, busy;
    logic [2:0] irq_id;
    logic [7:0] irq_vec;
    wire  [7:0] intr_bus;
    logic       tb_drv_en = 1'b0;
    logic [7:0] tb_drv = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_cnt = 0;

    assign intr_bus = tb_drv_en ? tb_drv : 8'hzz;

    intr_cpu_ack_master #(
        .ACK_DELAY(ACK_DELAY), .PULSE_W(PULSE_W),
        .CFG_HOLD(CFG_HOLD), .VEC_TIMEOUT(VEC_TIMEOUT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .intr_out(intr_out), .intr_in(intr_in),
        .bus_oe(bus_oe), .intr_bus(intr_bus), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .exp_prefix(exp_prefix),
        .cmpl_prefix(cmpl_prefix), .irq_valid(irq_valid), .irq_id(irq_id),
        .irq_vec(irq_vec), .isr_done(isr_done), .vec_err(vec_err),
        .to_err(to_err), .busy(busy)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;
    always @(posedge clk_in) if (cfg_ready) rdy_cnt <= rdy_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic apply_reset();
        rst_in = 1'b0; intr_out = 1'b0; cfg_valid = 1'b0; isr_done = 1'b0;
        bus_oe = 1'b0; tb_drv_en = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    // Expect a strobe whose first low cycle is seen at cycle t_exp; returns on the first high cycle after it.
    task automatic strobe(input string tag, input int t_exp);
        int t, w, budget;
        t = -1;
        budget = (t_exp > cyc) ? (t_exp - cyc + 20) : 20;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (!intr_in) begin
                t = cyc;
                break;
            end
        end
        check_eq({tag, "_time"}, t, t_exp);
        if (t < 0) return;
        w = 1;
        while (w < 40) begin
            @(negedge clk_in);
            if (intr_in) break;
            w++;
        end
        check_eq({tag, "_width"}, w, PULSE_W);
    endtask

    // Offer a config word and wait for acceptance; returns the accept cycle.
    task automatic cfg_word(input logic [7:0] d, output int t_acc);
        cfg_valid = 1'b1;
        cfg_data = d;
        t_acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (cfg_ready) begin
                t_acc = cyc;
                break;
            end
        end
        check_eq("cfg_bus", intr_bus, d);
    endtask

    // Full service after intr_out was sampled at cycle t0 with the DUT idle.
    task automatic do_service(input logic [7:0] vec, input logic [4:0] cpre,
                              input int vec_gap, input int isr_gap, input int t0);
        int tv, ti;
        logic [7:0] cword;
        cword = {cpre, vec[2:0]};
        strobe("ack1", t0 + ACK_DELAY + 1);
        intr_out = 1'b0;
        repeat (vec_gap) @(negedge clk_in);
        bus_oe = 1'b1; tb_drv_en = 1'b1; tb_drv = vec;
        tv = cyc + 1;
        @(negedge clk_in);
        check_eq("bus_ctrl_owned", intr_bus, vec);
        bus_oe = 1'b0; tb_drv_en = 1'b0;
        check_eq("irq_vec", irq_vec, vec);
        strobe("ack2", tv + ACK_DELAY + 1);
        check_eq("irq_valid_set", irq_valid, 1);
        check_eq("irq_id", irq_id, vec[2:0]);
        repeat (isr_gap) @(negedge clk_in);
        check_eq("irq_valid_hold", irq_valid, 1);
        isr_done = 1'b1;
        ti = cyc + 1;
        @(negedge clk_in);
        isr_done = 1'b0;
        check_eq("irq_valid_clr", irq_valid, 0);
        check_eq("cmpl_word", intr_bus, cword);
        strobe("ack3", ti + ACK_DELAY + 1);
        check_eq("idle_busy", busy, 0);
        check_eq("cmpl_hold", intr_bus, cword);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t0, tp, b, r0, lows, te, ea;
        logic [7:0] words [4];
        logic [7:0] vec;
        logic [2:0] id;
        words[0] = 8'hAE; words[1] = 8'hE2; words[2] = 8'h8A; words[3] = 8'hC6;

        // Reset state
        repeat (2) @(negedge clk_in);
        check_eq("rst_intr_in", intr_in, 1);
        check_eq("rst_irq_valid", irq_valid, 0);
        check_eq("rst_irq_id", irq_id, 0);
        check_eq("rst_irq_vec", irq_vec, 0);
        check_eq("rst_cfg_ready", cfg_ready, 0);
        check_eq("rst_errs", {vec_err, to_err}, 0);
        check_eq("rst_busy", busy, 0);
        rst_in = 1'b1;
        @(negedge clk_in);
        tb_drv_en = 1'b1; tb_drv = 8'hA5;
        @(negedge clk_in);
        check_eq("bus_free_after_reset", intr_bus, 8'hA5);
        tb_drv_en = 1'b0;
        @(negedge clk_in);

        // Single config word
        r0 = rdy_cnt;
        tp = cyc;
        cfg_word(8'h01, t);
        cfg_valid = 1'b0;
        check_eq("cfg_accept_time", t, tp + 1);
        b = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (!busy) break;
            b++;
        end
        check_eq("cfg_busy_len", b, 1 + CFG_HOLD);
        repeat (3) @(negedge clk_in);
        check_eq("cfg_ready_pulses", rdy_cnt - r0, 1);
        check_eq("cfg_bus_hold", intr_bus, 8'h01);

        // Polling service with a fixed vector
        exp_prefix = 5'b01011; cmpl_prefix = 5'b10100;
        intr_out = 1'b1; t0 = cyc + 1;
        do_service(8'b01011_101, 5'b10100, 3, 4, t0);

        // Back-to-back config words, then a service raised while CFG is still running
        tp = cyc;
        for (int k = 0; k < 4; k++) begin
            cfg_word(words[k], t);
            if (k == 0) check_eq("cfg0_time", t, tp + 1);
            else        check_eq("cfgk_time", t, tp + CFG_HOLD + 2);
            tp = t;
        end
        cfg_valid = 1'b0;
        intr_out = 1'b1;
        t0 = tp + CFG_HOLD + 2;
        cmpl_prefix = 5'b01100;
        exp_prefix = 5'($urandom);
        id = 3'($urandom);
        do_service({exp_prefix, id}, 5'b01100, $urandom_range(0, 20), $urandom_range(0, 15), t0);

        // Ten randomized services
        for (int n = 0; n < 10; n++) begin
            exp_prefix = 5'($urandom);
            id = 3'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk_in);
            intr_out = 1'b1; t0 = cyc + 1;
            do_service({exp_prefix, id}, 5'b01100, $urandom_range(0, 40), $urandom_range(0, 15), t0);
        end

        // intr_out and cfg_valid together: service wins, config waits for IDLE
        r0 = rdy_cnt;
        id = 3'($urandom);
        intr_out = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h5C;
        t0 = cyc + 1;
        do_service({exp_prefix, id}, 5'b01100, 2, 2, t0);
        check_eq("cfg_held_off", rdy_cnt - r0, 0);
        @(negedge clk_in);
        check_eq("cfg_after_service", cfg_ready, 1);
        check_eq("cfg_after_service_bus", intr_bus, 8'h5C);
        cfg_valid = 1'b0;
        repeat (4) @(negedge clk_in);

        // Asynchronous reset while the ISR is pending
        vec = {exp_prefix, 3'b011};
        intr_out = 1'b1; t0 = cyc + 1;
        strobe("rst_ack1", t0 + ACK_DELAY + 1);
        intr_out = 1'b0;
        bus_oe = 1'b1; tb_drv_en = 1'b1; tb_drv = vec;
        t = cyc + 1;
        @(negedge clk_in);
        bus_oe = 1'b0; tb_drv_en = 1'b0;
        strobe("rst_ack2", t + ACK_DELAY + 1);
        repeat (3) @(negedge clk_in);
        check_eq("isr_pending", irq_valid, 1);
        #1 rst_in = 1'b0;
        #1;
        check_eq("async_rst_irq_valid", irq_valid, 0);
        check_eq("async_rst_irq_id", irq_id, 0);
        check_eq("async_rst_irq_vec", irq_vec, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_intr_in", intr_in, 1);
        apply_reset();

        // Vector prefix mismatch goes to ERR and stops strobing
        exp_prefix = 5'b10011;
        vec = 8'b01011_010;
        intr_out = 1'b1; t0 = cyc + 1;
        strobe("err_ack1", t0 + ACK_DELAY + 1);
        intr_out = 1'b0;
        bus_oe = 1'b1; tb_drv_en = 1'b1; tb_drv = vec;
        @(negedge clk_in);
        bus_oe = 1'b0; tb_drv_en = 1'b0;
        check_eq("vec_err_set", vec_err, vec[7:3] != exp_prefix);
        check_eq("vec_err_irq_vec", irq_vec, vec);
        check_eq("vec_err_no_to", to_err, 0);
        lows = 0;
        intr_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (!intr_in) lows++;
        end
        intr_out = 1'b0;
        check_eq("err_no_strobes", lows, 0);
        check_eq("err_busy", busy, 1);
        check_eq("err_irq_valid", irq_valid, 0);
        check_eq("err_sticky", vec_err, 1);
        apply_reset();
        check_eq("vec_err_cleared", vec_err, 0);

        // Vector timeout
        intr_out = 1'b1; t0 = cyc + 1;
        strobe("to_ack1", t0 + ACK_DELAY + 1);
        intr_out = 1'b0;
        ea = cyc;
        te = -1; lows = 0;
        for (int i = 0; i < VEC_TIMEOUT + 40; i++) begin
            @(negedge clk_in);
            if (!intr_in) lows++;
            if (to_err) begin
                te = cyc;
                break;
            end
        end
        check_eq("to_err_time", te, ea + VEC_TIMEOUT);
        check_eq("to_no_strobes", lows, 0);
        repeat (5) @(negedge clk_in);
        check_eq("to_busy", busy, 1);
        check_eq("to_intr_in", intr_in, 1);
        check_eq("to_no_vec_err", vec_err, 0);
        apply_reset();
        check_eq("to_err_cleared", to_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/intr_cpu_ack_master.md
Name: intr_cpu_ack_master

Overview:
- Processor-side agent for the 8-line interrupt controller bus protocol; it sits between the CPU core and the controller's intr_out / intr_in / intr_bus / bus_oe pins.
- Writes configuration words onto intr_bus, then services each interrupt through three acknowledge strobes: interrupt ack, vector ack, ISR-complete.
- Presents the captured vector ID to the core and drives the completion word back to the controller.

Parameters:
ACK_DELAY, 6, idle cycles inserted before each intr_in strobe (range 1-255)
PULSE_W, 1, width in cycles of each active-low intr_in strobe (range 1-15)
CFG_HOLD, 1, cycles each config word is held on the bus (range 1-15)
VEC_TIMEOUT, 255, maximum cycles to wait for bus_oe=1 after the first ack

Ports:
clk_in  input  1  system clock, rising-edge
rst_in  input  1  asynchronous reset, active-low
intr_out  input  1  interrupt request from controller, active-high level
intr_in  output  1  acknowledge strobe to controller, active-low
bus_oe  input  1  1 = controller drives intr_bus; 0 = this block may drive it
intr_bus  inout  8  shared config / vector / completion bus
cfg_data  input  8  config word from core
cfg_valid  input  1  config word available
cfg_ready  output  1  one-cycle pulse: config word accepted
exp_prefix  input  5  expected vector bits [7:3]
cmpl_prefix  input  5  completion-word bits [7:3]
irq_valid  output  1  vector captured, ISR pending
irq_id  output  3  captured interrupt number
irq_vec  output  8  full captured vector
isr_done  input  1  core finished the ISR; sampled only while irq_valid=1
vec_err  output  1  sticky: vector prefix mismatch
to_err  output  1  sticky: bus_oe timeout
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst_in=0, asynchronous):
  - intr_in=1; intr_bus released to Z; bus_q=0; drv_en=0.
  - irq_valid=0, irq_id=0, irq_vec=0, cfg_ready=0, vec_err=0, to_err=0, busy=0; FSM=IDLE.
  - Reset mid-transaction aborts it; no strobe completes.
- Bus drive: intr_bus = bus_q when (drv_en=1 and bus_oe=0), else Z. The block never drives while bus_oe=1. drv_en is set on the first config or completion word and stays set until reset.
- FSM states: IDLE, CFG, INT_DLY, ACK1, VEC_WAIT, VEC_DLY, ACK2, ISR, CMPL_DLY, ACK3, ERR.
- IDLE:
  - intr_out=1 -> INT_DLY. intr_out has priority over cfg_valid when both are high in the same cycle.
  - Else cfg_valid=1 -> bus_q<=cfg_data, drv_en<=1, cfg_ready pulses, -> CFG.
- CFG: hold bus_q for CFG_HOLD cycles -> IDLE. A CFG sequence in progress is not preempted by intr_out.
- INT_DLY: count ACK_DELAY cycles -> ACK1.
- ACK1:
  - intr_in=0 for PULSE_W cycles -> VEC_WAIT.
  - The first low cycle begins ACK_DELAY+1 edges after the edge that sampled intr_out=1.
- VEC_WAIT:
  - On the first edge with bus_oe=1, capture intr_bus into irq_vec.
  - If irq_vec[7:3] != exp_prefix: set vec_err, -> ERR.
  - Otherwise -> VEC_DLY.
  - After VEC_TIMEOUT cycles with no bus_oe=1: set to_err, -> ERR.
- VEC_DLY: ACK_DELAY cycles -> ACK2.
- ACK2: intr_in=0 for PULSE_W cycles, then irq_valid<=1, irq_id<=irq_vec[2:0] -> ISR.
- ISR:
  - Wait for isr_done=1.
  - On that edge: irq_valid<=0, bus_q<={cmpl_prefix, irq_id}, drv_en<=1 -> CMPL_DLY.
- CMPL_DLY: ACK_DELAY cycles with the completion word on the bus -> ACK3.
- ACK3:
  - intr_in=0 for PULSE_W cycles -> IDLE.
  - The completion word stays on the bus after ACK3.
  - If intr_out is still high, the next service starts with the normal ACK_DELAY.
- ERR: terminal; intr_in held 1, bus released, busy=1; only reset exits.
- intr_in is registered; no glitches between strobes. Consecutive strobes are always separated by at least ACK_DELAY high cycles.
- intr_out falling during INT_DLY/ACK1 is ignored; the sequence completes.
- Counters saturate and never wrap. Timeout counting starts on the cycle after ACK1 ends.

Test Plan:
1. Reset, then cfg_valid with cfg_data=8'h01 -> cfg_ready pulses once; intr_bus=8'h01 while bus_oe=0; busy high for 1+CFG_HOLD cycles.
2. Polling service: exp_prefix=5'b01011, cmpl_prefix=5'b10100; controller raises intr_out, then drives 8'b01011_101 with bus_oe=1 after ACK1 -> strobe ACK1 appears 7 edges after intr_out is sampled; irq_id=3'b101, irq_valid until isr_done; bus=8'b10100_101 before ACK3; exactly three 1-cycle intr_in strobes.
3. Priority sequence: four cfg words 8'hAE, 8'hE2, 8'h8A, 8'hC6 back-to-back, then intr_out -> all four appear on the bus in order; ten services each return {5'b01100, id}.
4. Vector mismatch: exp_prefix=5'b10011, controller drives 8'b01011_010 -> vec_err=1, FSM ERR, no ACK2, intr_in held 1 until reset.
5. Timeout: intr_out=1, bus_oe never asserts -> to_err=1 exactly VEC_TIMEOUT cycles after ACK1 ends; intr_bus never contended.
6. Simultaneous intr_out and cfg_valid in IDLE -> service first, cfg_ready=0 until back in IDLE. Reset asserted mid-ISR -> all outputs return to reset values immediately (asynchronously), intr_bus=Z.
